// File: rtl/tdm_demux_pkg.sv
// Shared types and constants for the 4-slot TDM demultiplexer.
package tdm_demux_pkg;

  localparam int unsigned NSLOT  = 4;
  localparam int unsigned SLOT_W = 2;
  localparam int unsigned W_DEF  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef logic [SLOT_W-1:0] slot_t;

endpackage

// File: rtl/tdm_demux4_if.sv
// Serial-in / channel-parallel-out bundle of the TDM demultiplexer.
interface tdm_demux4_if
  import tdm_demux_pkg::*;
#(
  parameter int unsigned W = W_DEF
) ();

  logic         EN;
  logic         SYNC;
  logic [W-1:0] DIN;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] C;
  logic [W-1:0] D;
  slot_t        S;
  logic         VALID;
  logic         ERR;

  modport master (
    output EN, SYNC, DIN,
    input  A, B, C, D, S, VALID, ERR
  );

  modport slave (
    input  EN, SYNC, DIN,
    output A, B, C, D, S, VALID, ERR
  );

endinterface

// File: rtl/tdm_slot_ctr.sv
// Slot counter and IDLE/RUN framing state; decodes which register each
// enabled cycle writes.
module tdm_slot_ctr
  import tdm_demux_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  i_en,
  input  logic  i_sync,
  output slot_t o_s,
  output logic  o_start_c,
  output logic  o_store_c,
  output logic  o_last_c,
  output logic  o_resync_c
);

  localparam slot_t LAST_SLOT = slot_t'(NSLOT - 1);

  state_e r_state;
  state_e w_state_nxt;
  slot_t  r_s;
  slot_t  w_s_nxt;

  // State and slot index register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_s     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_s     <= w_s_nxt;
    end
  end

  // Next state: SYNC always restarts at slot 1; S returns to 0 only on completion
  always_comb begin
    w_state_nxt = r_state;
    w_s_nxt     = r_s;
    if (i_en) begin
      unique case (r_state)
        IDLE: begin
          if (i_sync) begin
            w_state_nxt = RUN;
            w_s_nxt     = slot_t'(1);
          end
        end
        RUN: begin
          if (i_sync) begin
            w_s_nxt = slot_t'(1);
          end else if (r_s == LAST_SLOT) begin
            w_state_nxt = IDLE;
            w_s_nxt     = '0;
          end else begin
            w_s_nxt = slot_t'(r_s + slot_t'(1));
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_s_nxt     = '0;
        end
      endcase
    end
  end

  // Write-enable decodes for the datapath
  always_comb begin
    o_start_c  = 1'b0;
    o_store_c  = 1'b0;
    o_last_c   = 1'b0;
    o_resync_c = 1'b0;
    if (i_en) begin
      o_start_c = i_sync;
      if (r_state == RUN) begin
        o_resync_c = i_sync;
        o_last_c   = !i_sync && (r_s == LAST_SLOT);
        o_store_c  = !i_sync && (r_s != LAST_SLOT);
      end
    end
  end

  assign o_s = r_s;

endmodule

// File: rtl/tdm_demux4.sv
// 1-to-4 TDM demultiplexer: collects a SYNC-framed run of four slots and
// publishes them together on A..D with a one-cycle VALID strobe.
module tdm_demux4
  import tdm_demux_pkg::*;
#(
  parameter int unsigned W = W_DEF
) (
  input logic         clk,
  input logic         rst_n,
  tdm_demux4_if.slave bus
);

  slot_t        w_s;
  logic         w_start;
  logic         w_store;
  logic         w_last;
  logic         w_resync;

  logic [W-1:0] r_sh0;
  logic [W-1:0] r_sh1;
  logic [W-1:0] r_sh2;
  logic [W-1:0] r_a;
  logic [W-1:0] r_b;
  logic [W-1:0] r_c;
  logic [W-1:0] r_d;
  logic         r_valid;
  logic         r_err;

  tdm_slot_ctr u_slot_ctr (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_en       (bus.EN),
    .i_sync     (bus.SYNC),
    .o_s        (w_s),
    .o_start_c  (w_start),
    .o_store_c  (w_store),
    .o_last_c   (w_last),
    .o_resync_c (w_resync)
  );

  // Slot 3 bypasses the shadow so the frame lands on A..D in one edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh0   <= '0;
      r_sh1   <= '0;
      r_sh2   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
      r_d     <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= w_last;
      r_err   <= w_resync;
      if (w_start) begin
        r_sh0 <= bus.DIN;
      end
      if (w_store && (w_s == slot_t'(1))) begin
        r_sh1 <= bus.DIN;
      end
      if (w_store && (w_s == slot_t'(2))) begin
        r_sh2 <= bus.DIN;
      end
      if (w_last) begin
        r_a <= r_sh0;
        r_b <= r_sh1;
        r_c <= r_sh2;
        r_d <= bus.DIN;
      end
    end
  end

  assign bus.A     = r_a;
  assign bus.B     = r_b;
  assign bus.C     = r_c;
  assign bus.D     = r_d;
  assign bus.S     = w_s;
  assign bus.VALID = r_valid;
  assign bus.ERR   = r_err;

endmodule
